clock_setup_ctrl: RTL and testbench

Setup and run/pause sequencer for the chess clock. Holds the eight BCD preset digits edited by the player buttons: digits 1-4 are player A MM:SS, digits 5-8 are player B MM:SS. On start it issues a one-tick load impulse with stop asserted, so the timer loader captures the presets. It then releases stop to run the clock and supports pause/resume and re-editing.

---
 rtl/clock_pkg.sv | 31 +++
 rtl/clock_setup_ctrl_btn_edge.sv | 28 ++
 rtl/clock_setup_ctrl.sv | 123 ++++++++++++
 tb/tb_clock_setup_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared types and helpers for the chess clock setup sequencer.
//   state_t     - sequencer states (EDIT, LOAD, RUN, PAUSED)
//   bcd_t       - one 4-bit BCD preset digit
//   TENS_MAX    - highest legal tens-of-minutes/seconds digit
//   UNITS_MAX   - highest legal units digit
//   digit_max() - upper limit of the digit at a given index (even = tens)
//   bcd_inc()   - modular increment of a digit within its limit
package clock_pkg;

  typedef enum logic [1:0] {
    ST_EDIT   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_PAUSED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t TENS_MAX  = 4'd5;
  localparam bcd_t UNITS_MAX = 4'd9;

  function automatic bcd_t digit_max(input logic [2:0] idx);
    return idx[0] ? UNITS_MAX : TENS_MAX;
  endfunction

  // ">=" rather than "==" so a digit can never get stuck above its limit.
  function automatic bcd_t bcd_inc(input bcd_t d, input logic [2:0] idx);
    return (d >= digit_max(idx)) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/clock_setup_ctrl_btn_edge.sv
// btn_edge: CE-qualified rising-edge detector for one debounced button.
//   i_clk  - system clock
//   i_clr  - asynchronous active-high clear (previous-level register -> 0)
//   i_ce   - tick enable; the previous level is sampled only on CE ticks
//   i_btn  - debounced button level
//   o_edge - high for the CE tick on which the button is seen rising
module btn_edge (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_ce,
  input  logic i_btn,
  output logic o_edge
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_prev <= 1'b0;
    end else if (i_ce) begin
      r_prev <= i_btn;
    end
  end

  // Clearing r_prev makes a button held through reset count as one edge.
  assign o_edge = i_ce & i_btn & ~r_prev;

endmodule

// File: rtl/clock_setup_ctrl.sv
// clock_setup_ctrl: preset editor and run/pause sequencer for the chess clock.
//   CLK        - system clock
//   CLR        - asynchronous active-high reset
//   CE         - tick enable for all non-reset state
//   BTN_NEXT   - rising edge moves the edit cursor (wraps 7 -> 0)
//   BTN_INC    - rising edge increments the digit under the cursor
//   BTN_START  - rising edge starts (via LOAD) or resumes
//   BTN_PAUSE  - rising edge pauses a running clock
//   O_D        - eight BCD preset digits, digit k on [4k-1:4k-4]
//   O_SEL      - cursor index (0 = digit 1)
//   O_IMPULSE  - one-tick load strobe for the timer loader
//   O_STOP     - 1 = timers held/loadable, 0 = running
//   O_RUN      - 1 while running
module clock_setup_ctrl
  import clock_pkg::*;
#(
  parameter int DEF_MT = 0,
  parameter int DEF_MU = 5,
  parameter int DEF_ST = 0,
  parameter int DEF_SU = 0
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        CE,
  input  logic        BTN_NEXT,
  input  logic        BTN_INC,
  input  logic        BTN_START,
  input  logic        BTN_PAUSE,
  output logic [31:0] O_D,
  output logic [2:0]  O_SEL,
  output logic        O_IMPULSE,
  output logic        O_STOP,
  output logic        O_RUN
);

  // Per-player pattern MM:SS, repeated for A (digits 1-4) and B (5-8).
  localparam bcd_t DEF_DIGIT [4] = '{bcd_t'(DEF_MT), bcd_t'(DEF_MU),
                                     bcd_t'(DEF_ST), bcd_t'(DEF_SU)};

  state_t     r_state;
  state_t     w_state_next;
  bcd_t       r_digits [8];
  logic [2:0] r_sel;

  logic w_next_edge;
  logic w_inc_edge;
  logic w_start_edge;
  logic w_pause_edge;
  logic w_presets_valid;

  btn_edge u_edge_next  (.i_clk(CLK), .i_clr(CLR), .i_ce(CE), .i_btn(BTN_NEXT),  .o_edge(w_next_edge));
  btn_edge u_edge_inc   (.i_clk(CLK), .i_clr(CLR), .i_ce(CE), .i_btn(BTN_INC),   .o_edge(w_inc_edge));
  btn_edge u_edge_start (.i_clk(CLK), .i_clr(CLR), .i_ce(CE), .i_btn(BTN_START), .o_edge(w_start_edge));
  btn_edge u_edge_pause (.i_clk(CLK), .i_clr(CLR), .i_ce(CE), .i_btn(BTN_PAUSE), .o_edge(w_pause_edge));

  // A zero preset for either player would flag the game over instantly.
  assign w_presets_valid =
    ((r_digits[0] | r_digits[1] | r_digits[2] | r_digits[3]) != 4'd0) &&
    ((r_digits[4] | r_digits[5] | r_digits[6] | r_digits[7]) != 4'd0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EDIT: begin
        if (w_start_edge && w_presets_valid) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_pause_edge) begin
          w_state_next = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (w_start_edge) begin
          w_state_next = ST_RUN;
        end else if (w_next_edge || w_inc_edge) begin
          w_state_next = ST_EDIT;
        end
      end
      default: w_state_next = ST_EDIT;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_EDIT;
    end else if (CE) begin
      r_state <= w_state_next;
    end
  end

  // Editing happens only in EDIT. A START edge (even a rejected one) takes
  // the tick, so a coincident NEXT/INC is dropped. Edges are already CE-gated.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_sel <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        r_digits[i] <= DEF_DIGIT[2'(i)];
      end
    end else if (r_state == ST_EDIT && !w_start_edge) begin
      if (w_next_edge) begin
        r_sel <= r_sel + 3'd1;
      end else if (w_inc_edge) begin
        r_digits[r_sel] <= bcd_inc(r_digits[r_sel], r_sel);
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_pack
    assign O_D[4*gi+3 -: 4] = r_digits[gi];
  end

  // Outputs are decodes of the state register, so they clear with CLR.
  assign O_SEL     = r_sel;
  assign O_IMPULSE = (r_state == ST_LOAD);
  assign O_STOP    = (r_state != ST_RUN);
  assign O_RUN     = (r_state == ST_RUN);

endmodule

// File: tb/tb_clock_setup_ctrl.sv
module tb_clock_setup_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        ce = 1'b1;
  logic        btn_next = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_pause = 1'b0;
  logic [31:0] o_d;
  logic [2:0]  o_sel;
  logic        o_impulse;
  logic        o_stop;
  logic        o_run;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clock_setup_ctrl dut (
    .CLK(clk), .CLR(clr), .CE(ce),
    .BTN_NEXT(btn_next), .BTN_INC(btn_inc),
    .BTN_START(btn_start), .BTN_PAUSE(btn_pause),
    .O_D(o_d), .O_SEL(o_sel), .O_IMPULSE(o_impulse),
    .O_STOP(o_stop), .O_RUN(o_run)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0=NEXT 1=INC 2=START 3=PAUSE: one tick high, one tick low.
  task automatic press(input int which);
    case (which)
      0: btn_next = 1'b1;
      1: btn_inc = 1'b1;
      2: btn_start = 1'b1;
      default: btn_pause = 1'b1;
    endcase
    tick();
    btn_next = 1'b0; btn_inc = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
    tick();
  endtask

  initial begin
    // Reset and idle
    tick(); tick();
    clr = 1'b0;
    tick(); tick();
    chk("reset_d", o_d, 32'h0050_0050);
    chk("reset_sel", {29'd0, o_sel}, 32'd0);
    chk("reset_stop", {31'd0, o_stop}, 32'd1);
    chk("reset_imp", {31'd0, o_impulse}, 32'd0);
    chk("reset_run", {31'd0, o_run}, 32'd0);

    // Cursor and units-digit wrap
    repeat (3) press(0);
    chk("sel_3", {29'd0, o_sel}, 32'd3);
    repeat (7) press(1);
    chk("d4_is_7", o_d, 32'h0050_7050);
    repeat (3) press(1);
    chk("d4_wrap0", o_d, 32'h0050_0050);
    repeat (5) press(0);
    chk("sel_wrap0", {29'd0, o_sel}, 32'd0);

    // Tens-digit wrap on digit 1: 1,2,3,4,5,0
    for (int i = 0; i < 6; i++) begin
      press(1);
      chk($sformatf("d1_step%0d", i), {28'd0, o_d[3:0]}, (i + 1) % 6);
    end

    // Start sequence
    btn_start = 1'b1; tick();
    chk("load_imp", {31'd0, o_impulse}, 32'd1);
    chk("load_stop", {31'd0, o_stop}, 32'd1);
    btn_start = 1'b0; tick();
    chk("run_imp", {31'd0, o_impulse}, 32'd0);
    chk("run_stop", {31'd0, o_stop}, 32'd0);
    chk("run_run", {31'd0, o_run}, 32'd1);
    press(1); press(0);
    chk("run_frozen_d", o_d, 32'h0050_0050);
    chk("run_frozen_sel", {29'd0, o_sel}, 32'd0);

    // Pause and resume without reload
    press(3);
    chk("pause_stop", {31'd0, o_stop}, 32'd1);
    chk("pause_run", {31'd0, o_run}, 32'd0);
    btn_start = 1'b1; tick();
    chk("resume_noimp", {31'd0, o_impulse}, 32'd0);
    chk("resume_run", {31'd0, o_run}, 32'd1);
    btn_start = 1'b0; tick();

    // Pause, NEXT -> EDIT with cursor untouched, then START reloads
    press(3);
    press(0);
    chk("p2e_sel", {29'd0, o_sel}, 32'd0);
    chk("p2e_run", {31'd0, o_run}, 32'd0);
    press(0);
    chk("edit_sel1", {29'd0, o_sel}, 32'd1);
    btn_start = 1'b1; tick();
    chk("reload_imp", {31'd0, o_impulse}, 32'd1);
    btn_start = 1'b0; tick();
    chk("reload_run", {31'd0, o_run}, 32'd1);

    // Pause, INC -> EDIT (digit untouched), then CE 1-0-0-1 across LOAD
    press(3);
    press(1);
    chk("p2e_inc_d", o_d, 32'h0050_0050);
    btn_start = 1'b1; tick();
    chk("ce_load_imp", {31'd0, o_impulse}, 32'd1);
    btn_start = 1'b0; ce = 1'b0; tick();
    chk("ce0_imp_a", {31'd0, o_impulse}, 32'd1);
    tick();
    chk("ce0_imp_b", {31'd0, o_impulse}, 32'd1);
    chk("ce0_stop", {31'd0, o_stop}, 32'd1);
    ce = 1'b1; tick();
    chk("ce1_imp", {31'd0, o_impulse}, 32'd0);
    chk("ce1_run", {31'd0, o_run}, 32'd1);

    // START + NEXT together in PAUSED -> RUN, cursor unchanged
    press(3);
    btn_start = 1'b1; btn_next = 1'b1; tick();
    chk("pboth_run", {31'd0, o_run}, 32'd1);
    btn_start = 1'b0; btn_next = 1'b0; tick();
    chk("pboth_sel", {29'd0, o_sel}, 32'd1);

    // Zero guard: digit 2 five increments 5 -> 0 makes player A 00:00
    press(3);
    press(0);
    repeat (5) press(1);
    chk("zero_d", o_d, 32'h0050_0000);
    btn_start = 1'b1; tick();
    chk("zero_noimp", {31'd0, o_impulse}, 32'd0);
    chk("zero_stop", {31'd0, o_stop}, 32'd1);
    btn_start = 1'b0; tick();
    press(0);
    chk("zero_edit_sel", {29'd0, o_sel}, 32'd2);
    // START beats NEXT in EDIT even when START is rejected
    btn_start = 1'b1; btn_next = 1'b1; tick();
    btn_start = 1'b0; btn_next = 1'b0; tick();
    chk("prio_sel", {29'd0, o_sel}, 32'd2);
    chk("prio_run", {31'd0, o_run}, 32'd0);

    // Make A = 00:10, start, then CLR in LOAD
    press(1);
    chk("a_0010_d", o_d, 32'h0050_0100);
    btn_start = 1'b1; tick();
    chk("pre_clr_imp", {31'd0, o_impulse}, 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("clr_imp", {31'd0, o_impulse}, 32'd0);
    chk("clr_d", o_d, 32'h0050_0050);
    chk("clr_sel", {29'd0, o_sel}, 32'd0);
    chk("clr_stop", {31'd0, o_stop}, 32'd1);
    // START still held through release: counts as an edge on the first tick
    tick();
    clr = 1'b0;
    tick();
    chk("held_start_imp", {31'd0, o_impulse}, 32'd1);
    tick();
    chk("held_start_run", {31'd0, o_run}, 32'd1);
    btn_start = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
